// File: rtl/wb_pkg.sv
// Shared sizing defaults and buffer entry layout for the writeback stage.
// An entry packs as {rd_num, data}: register number in the upper bits.
package wb_pkg;

    localparam int WORD_DEF  = 32;
    localparam int W_RD_DEF  = 5;
    localparam int DEPTH_DEF = 4;
    localparam int W_CNT_DEF = 32;

    typedef struct packed {
        logic [W_RD_DEF-1:0] rd_num;
        logic [WORD_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback buffer: storage, head/tail pointers, occupancy and
// per-entry valid bits exposed for the pending-write lookup.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int WORD  = WORD_DEF,
    parameter int W_RD  = W_RD_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [W_RD-1:0]                num_i,
    input  logic [WORD-1:0]                data_i,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [W_RD-1:0]                head_num_o,
    output logic [WORD-1:0]                head_data_o,
    output logic [PTR_W-1:0]               tail_o,
    output logic [DEPTH-1:0]               ent_vld_o,
    output logic [DEPTH-1:0][W_RD-1:0]     ent_num_o,
    output logic [DEPTH-1:0][WORD-1:0]     ent_data_o
);

    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = W_RD + WORD;

    logic [PTR_W-1:0]                head_q, head_d;
    logic [PTR_W-1:0]                tail_q, tail_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [DEPTH-1:0]                vld_q, vld_d;
    logic [DEPTH-1:0][ENTRY_W-1:0]   mem_q, mem_d;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign tail_o  = tail_q;
    assign ent_vld_o = vld_q;
    assign head_num_o  = mem_q[head_q][WORD +: W_RD];
    assign head_data_o = mem_q[head_q][0 +: WORD];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_num_o[i]  = mem_q[i][WORD +: W_RD];
            ent_data_o[i] = mem_q[i][0 +: WORD];
        end
    end

    // The caller never pushes while full nor pops while empty.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        vld_d  = vld_q;
        mem_d  = mem_q;
        if (push_i) begin
            mem_d[tail_q] = {num_i, data_i};
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + PTR_W'(1);
        end
        if (pop_i) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PTR_W'(1);
        end
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            vld_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

    // Payload storage carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: buffers retired results, drains them to the shared
// register-file port, and serves decode's pending-write lookup (WB_FWD_EN adds data forwarding).
module wb_stage
    import wb_pkg::*;
#(
    parameter int WORD  = WORD_DEF,
    parameter int W_RD  = W_RD_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int W_CNT = W_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             v_i,
    output logic             stall_o,
    input  logic             wb_i,
    input  logic [W_RD-1:0]  rd_num_i,
    input  logic [WORD-1:0]  rd_data_i,
    input  logic             rf_busy_i,
    output logic             rf_we_o,
    output logic [W_RD-1:0]  rf_num_o,
    output logic [WORD-1:0]  rf_data_o,
    input  logic [W_RD-1:0]  chk_num_i,
    output logic             chk_hit_o,
    output logic [WORD-1:0]  chk_data_o,
    output logic [W_CNT-1:0] ret_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic                       full, empty, accept, push;
    logic [W_RD-1:0]            head_num;
    logic [WORD-1:0]            head_data;
    logic [PTR_W-1:0]           tail;
    logic [DEPTH-1:0]           ent_vld;
    logic [DEPTH-1:0][W_RD-1:0] ent_num;
    logic [DEPTH-1:0][WORD-1:0] ent_data;
    logic [W_CNT-1:0]           ret_cnt_q, ret_cnt_d;
    logic [PTR_W-1:0]           idx;
    logic                       found;
    logic [WORD-1:0]            fwd_data;

    assign stall_o = full;
    assign accept  = v_i & ~full;
    assign push    = accept & wb_i;
    assign rf_we_o = ~empty & ~rf_busy_i;
    assign rf_num_o  = empty ? '0 : head_num;
    assign rf_data_o = empty ? '0 : head_data;

    wb_fifo #(
        .WORD  (WORD),
        .W_RD  (W_RD),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (rf_we_o),
        .num_i       (rd_num_i),
        .data_i      (rd_data_i),
        .full_o      (full),
        .empty_o     (empty),
        .head_num_o  (head_num),
        .head_data_o (head_data),
        .tail_o      (tail),
        .ent_vld_o   (ent_vld),
        .ent_num_o   (ent_num),
        .ent_data_o  (ent_data)
    );

    // Walk from the youngest entry (tail-1) back so the first match wins.
    always_comb begin
        idx      = '0;
        found    = 1'b0;
        fwd_data = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            idx = tail - PTR_W'(k);
            if (!found && ent_vld[idx] && (ent_num[idx] == chk_num_i)) begin
                found    = 1'b1;
                fwd_data = ent_data[idx];
            end
        end
    end

    assign chk_hit_o = found;

`ifdef WB_FWD_EN
    assign chk_data_o = fwd_data;
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_data;
    assign chk_data_o = '0;
`endif

    always_comb begin
        ret_cnt_d = ret_cnt_q;
        if (accept) ret_cnt_d = ret_cnt_q + W_CNT'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ret_cnt_q <= '0;
        else     ret_cnt_q <= ret_cnt_d;
    end

    assign ret_cnt_o = ret_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (default and WB_FWD_EN builds).
module tb_wb_stage;

    localparam int WORD  = 32;
    localparam int W_RD  = 5;
    localparam int W_CNT = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             v_i, wb_i, rf_busy_i;
    logic [W_RD-1:0]  rd_num_i, chk_num_i;
    logic [WORD-1:0]  rd_data_i;
    logic             stall_o, rf_we_o, chk_hit_o;
    logic [W_RD-1:0]  rf_num_o;
    logic [WORD-1:0]  rf_data_o, chk_data_o;
    logic [W_CNT-1:0] ret_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [W_CNT-1:0] exp_ret;

    always #5 clk = ~clk;

    wb_stage #(.WORD(WORD), .W_RD(W_RD), .DEPTH(4), .W_CNT(W_CNT)) dut (
        .clk        (clk),
        .rst        (rst),
        .v_i        (v_i),
        .stall_o    (stall_o),
        .wb_i       (wb_i),
        .rd_num_i   (rd_num_i),
        .rd_data_i  (rd_data_i),
        .rf_busy_i  (rf_busy_i),
        .rf_we_o    (rf_we_o),
        .rf_num_o   (rf_num_o),
        .rf_data_o  (rf_data_o),
        .chk_num_i  (chk_num_i),
        .chk_hit_o  (chk_hit_o),
        .chk_data_o (chk_data_o),
        .ret_cnt_o  (ret_cnt_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [W_RD-1:0] rd, input logic [WORD-1:0] d);
        v_i = 1'b1; wb_i = 1'b1; rd_num_i = rd; rd_data_i = d;
        step();
        v_i = 1'b0;
        exp_ret = exp_ret + 1;
    endtask

    task automatic test_reset();
        checks++;
        if (rf_we_o !== 1'b0 || stall_o !== 1'b0 || chk_hit_o !== 1'b0 ||
            chk_data_o !== '0 || ret_cnt_o !== '0) begin
            errors++;
            $display("FAIL reset_state: we=%b stall=%b hit=%b cdata=%h ret=%0d, want all 0",
                     rf_we_o, stall_o, chk_hit_o, chk_data_o, ret_cnt_o);
        end
    endtask

    task automatic test_single();
        rf_busy_i = 1'b0;
        push_one(5'd3, 32'h1234);
        checks++;
        if (rf_we_o !== 1'b1 || rf_num_o !== 5'd3 || rf_data_o !== 32'h1234 || ret_cnt_o !== exp_ret) begin
            errors++;
            $display("FAIL single_write: we=%b num=%0d data=%h ret=%0d, want 1 3 1234 %0d",
                     rf_we_o, rf_num_o, rf_data_o, ret_cnt_o, exp_ret);
        end
        step();
        checks++;
        if (rf_we_o !== 1'b0 || rf_num_o !== '0 || rf_data_o !== '0) begin
            errors++;
            $display("FAIL single_empty: we=%b num=%0d data=%h, want 0 0 0", rf_we_o, rf_num_o, rf_data_o);
        end
    endtask

    task automatic test_full_order();
        rf_busy_i = 1'b1;
        for (int i = 1; i <= 4; i++) push_one(W_RD'(i), 32'h100 + i);
        checks++;
        if (stall_o !== 1'b1 || ret_cnt_o !== exp_ret) begin
            errors++;
            $display("FAIL full_stall: stall=%b ret=%0d, want 1 %0d", stall_o, ret_cnt_o, exp_ret);
        end
        v_i = 1'b1; wb_i = 1'b1; rd_num_i = 5'd9; rd_data_i = 32'h999;
        step();
        v_i = 1'b0;
        checks++;
        if (stall_o !== 1'b1 || ret_cnt_o !== exp_ret) begin
            errors++;
            $display("FAIL full_reject: stall=%b ret=%0d, want 1 %0d", stall_o, ret_cnt_o, exp_ret);
        end
        rf_busy_i = 1'b0;
        #1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (rf_we_o !== 1'b1 || rf_num_o !== W_RD'(i) || rf_data_o !== 32'h100 + i) begin
                errors++;
                $display("FAIL drain_order%0d: we=%b num=%0d data=%h, want 1 %0d %h",
                         i, rf_we_o, rf_num_o, rf_data_o, i, 32'h100 + i);
            end
            step();
            if (i == 1) begin
                checks++;
                if (stall_o !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_release: stall=%b, want 0", stall_o);
                end
            end
        end
        checks++;
        if (rf_we_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_done: we=%b, want 0", rf_we_o);
        end
    endtask

    task automatic test_nowb();
        v_i = 1'b1; wb_i = 1'b0; rd_num_i = 5'd7; rd_data_i = 32'h77;
        step();
        v_i = 1'b0;
        exp_ret = exp_ret + 1;
        chk_num_i = 5'd7;
        #1;
        checks++;
        if (rf_we_o !== 1'b0 || ret_cnt_o !== exp_ret || chk_hit_o !== 1'b0) begin
            errors++;
            $display("FAIL no_writeback: we=%b ret=%0d hit=%b, want 0 %0d 0",
                     rf_we_o, ret_cnt_o, chk_hit_o, exp_ret);
        end
    endtask

    task automatic test_same_reg();
        logic [WORD-1:0] exp_fwd;
        rf_busy_i = 1'b1;
        push_one(5'd5, 32'hA);
        push_one(5'd5, 32'hB);
`ifdef WB_FWD_EN
        exp_fwd = 32'hB;
`else
        exp_fwd = 32'h0;
`endif
        chk_num_i = 5'd5;
        #1;
        checks++;
        if (chk_hit_o !== 1'b1 || chk_data_o !== exp_fwd) begin
            errors++;
            $display("FAIL lookup_hit: hit=%b data=%h, want 1 %h", chk_hit_o, chk_data_o, exp_fwd);
        end
        chk_num_i = 5'd6;
        #1;
        checks++;
        if (chk_hit_o !== 1'b0 || chk_data_o !== '0) begin
            errors++;
            $display("FAIL lookup_miss: hit=%b data=%h, want 0 0", chk_hit_o, chk_data_o);
        end
        rf_busy_i = 1'b0;
        #1;
        checks++;
        if (rf_we_o !== 1'b1 || rf_num_o !== 5'd5 || rf_data_o !== 32'hA) begin
            errors++;
            $display("FAIL same_reg_first: we=%b num=%0d data=%h, want 1 5 a", rf_we_o, rf_num_o, rf_data_o);
        end
        step();
        checks++;
        if (rf_we_o !== 1'b1 || rf_num_o !== 5'd5 || rf_data_o !== 32'hB) begin
            errors++;
            $display("FAIL same_reg_second: we=%b num=%0d data=%h, want 1 5 b", rf_we_o, rf_num_o, rf_data_o);
        end
        step();
    endtask

    task automatic test_full_drain();
        rf_busy_i = 1'b1;
        for (int i = 0; i < 4; i++) push_one(W_RD'(10 + i), 32'h200 + i);
        v_i = 1'b1; wb_i = 1'b1; rd_num_i = 5'd14; rd_data_i = 32'h204;
        rf_busy_i = 1'b0;
        step();
        checks++;
        if (stall_o !== 1'b0 || ret_cnt_o !== exp_ret || rf_num_o !== 5'd11) begin
            errors++;
            $display("FAIL full_pop_no_push: stall=%b ret=%0d num=%0d, want 0 %0d 11",
                     stall_o, ret_cnt_o, rf_num_o, exp_ret);
        end
        step();
        v_i = 1'b0;
        exp_ret = exp_ret + 1;
        checks++;
        if (ret_cnt_o !== exp_ret || rf_num_o !== 5'd12) begin
            errors++;
            $display("FAIL late_push: ret=%0d num=%0d, want %0d 12", ret_cnt_o, rf_num_o, exp_ret);
        end
        step();
        for (int i = 13; i <= 14; i++) begin
            checks++;
            if (rf_we_o !== 1'b1 || rf_num_o !== W_RD'(i) || rf_data_o !== 32'h200 + (i - 10)) begin
                errors++;
                $display("FAIL full_drain_tail%0d: we=%b num=%0d data=%h", i, rf_we_o, rf_num_o, rf_data_o);
            end
            step();
        end
        checks++;
        if (rf_we_o !== 1'b0) begin
            errors++;
            $display("FAIL full_drain_dup: we=%b, want 0 (no duplicate entry)", rf_we_o);
        end
    endtask

    task automatic test_reset_mid();
        rf_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) push_one(W_RD'(20 + i), 32'h300 + i);
        rf_busy_i = 1'b0;
        chk_num_i = 5'd21;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rf_we_o !== 1'b0 || stall_o !== 1'b0 || chk_hit_o !== 1'b0 ||
            chk_data_o !== '0 || ret_cnt_o !== '0) begin
            errors++;
            $display("FAIL async_reset: we=%b stall=%b hit=%b cdata=%h ret=%0d, want all 0",
                     rf_we_o, stall_o, chk_hit_o, chk_data_o, ret_cnt_o);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (rf_we_o !== 1'b0 || ret_cnt_o !== '0 || stall_o !== 1'b0 || rf_num_o !== '0) begin
            errors++;
            $display("FAIL post_reset: we=%b ret=%0d stall=%b num=%0d, want 0 0 0 0",
                     rf_we_o, ret_cnt_o, stall_o, rf_num_o);
        end
    endtask

    initial begin
        rst = 1'b1; v_i = 1'b0; wb_i = 1'b0; rf_busy_i = 1'b0;
        rd_num_i = '0; rd_data_i = '0; chk_num_i = '0;
        exp_ret = '0;
        #12;
        test_reset();
        rst = 1'b0;
        step();
        test_single();
        test_full_order();
        test_nowb();
        test_same_reg();
        test_full_drain();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly downstream of the execute stage.
- Accepts retired results (valid, writeback flag, destination register, data) into a small in-order buffer.
- Drains the buffer into the register-file write port, which is shared with other writers and can be busy.
- Gives decode a pending-write lookup for hazard detection; execute is held via stall_o when the buffer is full.

Parameters:
WORD, 32, data width of a result
W_RD, 5, destination register number width
DEPTH, 4, buffer entries; power of two, minimum 2
W_CNT, 32, retire counter width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
v_i  in  1  execute result valid
stall_o  out  1  hold execute; buffer full
wb_i  in  1  result writes a register
rd_num_i  in  W_RD  destination register
rd_data_i  in  WORD  result data
rf_busy_i  in  1  register-file write port taken by another writer this cycle
rf_we_o  out  1  register-file write enable
rf_num_o  out  W_RD  write register number
rf_data_o  out  WORD  write data
chk_num_i  in  W_RD  decode lookup register
chk_hit_o  out  1  buffered write pending to chk_num_i
chk_data_o  out  WORD  youngest pending data for chk_num_i (forwarding build only)
ret_cnt_o  out  W_CNT  accepted-instruction count

Behaviour:
- Accept condition: accept = v_i & ~stall_o.
- stall_o = (count == DEPTH), decoded from registered count only.
  - No push while full, even in a cycle that also pops.
  - The upstream stage holds its outputs while stalled.
- Push: on accept with wb_i=1, write {rd_num_i, rd_data_i} at tail; tail wraps mod DEPTH.
- Drop: on accept with wb_i=0, nothing is enqueued; the instruction is counted only.
- Drain:
  - rf_we_o = (count != 0) & ~rf_busy_i, combinational.
  - rf_num_o / rf_data_o = head entry.
  - On a clock edge with rf_we_o=1, head advances (wraps mod DEPTH).
  - rf_busy_i=1 holds the head entry with no loss.
  - When the buffer is empty, rf_num_o and rf_data_o are 0.
- Timing: latency from accept edge to earliest rf_we_o is 1 cycle. Throughput is 1 result/cycle with no contention.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Ordering: strictly in order. Two pending writes to the same register retire oldest first.
- Lookup:
  - chk_hit_o = 1 if any valid entry matches chk_num_i, combinational.
  - The match covers entries in the buffer only. The result being presented on the input this cycle is not included.
- ret_cnt_o: increments by 1 on every accept and wraps at 2^W_CNT.
- Reset (asynchronous, effective mid-operation):
  - Pointers, count, entry valids and ret_cnt_o go to 0; pending writes are discarded.
  - Outputs immediately: rf_we_o=0, stall_o=0, chk_hit_o=0, chk_data_o=0.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined:
  - chk_data_o is the data of the youngest valid entry matching chk_num_i; 0 on no hit.
  - Search runs from tail-1 back toward head.
- Undefined: chk_data_o tied 0; chk_hit_o still works as a scoreboard bit and decode must stall on a hit.

Decomposition:
- Shared package (params header): WORD, W_RD, DEPTH defaults, and the buffer entry struct/constant layout {rd_num, data}.
- One natural sub-module: wb_fifo, which holds storage, pointers, count and full/empty flags, and exposes per-entry valid/num/data for the lookup.
- Lookup, retire counter and port glue stay in wb_stage.

Test Plan:
1. Reset, then accept v_i=1, wb_i=1, rd=3, data=0x1234, rf_busy_i=0 → next cycle rf_we_o=1, rf_num_o=3, rf_data_o=0x1234; ret_cnt_o=1; buffer empty after that edge.
2. rf_busy_i=1 held; push 4 writes (rd 1..4) → stall_o=1 after 4th accept. A 5th v_i is not accepted and ret_cnt_o stays 4. Release busy → writes appear in order 1,2,3,4 on consecutive cycles, and stall_o drops after the first drain.
3. Accept wb_i=0, rd=7 → no rf_we_o, ret_cnt_o increments, chk_num_i=7 gives chk_hit_o=0.
4. With busy=1, push rd=5 data=0xA then rd=5 data=0xB → chk_hit_o=1 and chk_data_o=0xB (WB_FWD_EN). After draining, register 5 is written 0xA then 0xB.
5. Full buffer plus a simultaneous drain edge and v_i held → no push that edge; push occurs the following edge; no entry lost or duplicated.
6. Assert rst mid-drain with 3 entries pending → rf_we_o falls immediately with no clock; after release, count=0, ret_cnt_o=0, stall_o=0.
